// File: rtl/cpu_hatch_arbiter.sv
// Purpose : shares one hatch memory port between fetch (reads) and memory stage (reads/writes).
// Latency : grant is combinational in IDLE; response pulse appears 1 cycle after mem_rvalid.
// Backpr. : one transaction outstanding; requesters hold until gnt, mem_ready stalls the grant.
//
// Ports:
//   clk, rst_b                      clock, async active-low reset
//   if_req/if_addr -> if_gnt        fetch request, accepted when if_gnt=1
//   if_rvalid/if_rdata              fetch response (dropped when squashed by kill_4a)
//   dm_req/dm_we/dm_addr/dm_wdata   data request, accepted when dm_gnt=1
//   dm_rvalid/dm_rdata              data read data or write ack (rdata=0 on ack)
//   kill_4a                         squashes the in-flight fetch response
//   mem_*                           hatch memory port (req/ready, rvalid/rdata)
//   protocol_err                    sticky: response seen with nothing outstanding
module cpu_hatch_arbiter #(
  parameter int DATA_W        = 48,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              kill_4a,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              protocol_err
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_IF, S_WAIT_DM} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   streak_q;
  logic            drop_q;
  logic            pend_we_q;
  logic            sel_dm;

  // Data wins unless fetch has been waiting through a full streak of data grants.
  assign sel_dm = dm_req && !(if_req && (streak_q == STREAK_MAX));

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (dm_gnt)      state_d = S_WAIT_DM;
        else if (if_gnt) state_d = S_WAIT_IF;
      end
      S_WAIT_IF, S_WAIT_DM: begin
        if (mem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic. Gated by rst_b so the port is quiet while reset is held,
  // even if the requesters keep their requests up.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    if (rst_b && (state_q == S_IDLE)) begin
      mem_req = if_req | dm_req;
      if (sel_dm) begin
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
        dm_gnt    = mem_ready;
      end else if (if_req) begin
        mem_addr  = if_addr;
        if_gnt    = mem_ready;
      end
    end
  end

  // Streak counter, drop flag, pending write flag
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      streak_q  <= '0;
      drop_q    <= 1'b0;
      pend_we_q <= 1'b0;
    end else begin
      if (dm_gnt) begin
        pend_we_q <= dm_we;
        if (if_req) streak_q <= (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 1'b1;
        else        streak_q <= '0;
      end else if (if_gnt) begin
        streak_q <= '0;
      end

      // The fetch response cycle consumes the flag whether or not it was set.
      if ((state_q == S_WAIT_IF) && mem_rvalid)
        drop_q <= 1'b0;
      else if (kill_4a && ((state_q == S_WAIT_IF) || if_gnt))
        drop_q <= 1'b1;
    end
  end

  // Response routing
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      if_rvalid    <= 1'b0;
      if_rdata     <= '0;
      dm_rvalid    <= 1'b0;
      dm_rdata     <= '0;
      protocol_err <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if (mem_rvalid) begin
        case (state_q)
          S_WAIT_IF: begin
            // A kill arriving with the response squashes it too.
            if (!(drop_q || kill_4a)) begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end
          S_WAIT_DM: begin
            dm_rvalid <= 1'b1;
            dm_rdata  <= pend_we_q ? '0 : mem_rdata;
          end
          default: protocol_err <= 1'b1;
        endcase
      end
    end
  end

endmodule
